joy_router: RTL and testbench
=============================

JOY_ROUTER -- requirements
Module: joy_router

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of joystick ports (2..4).
REQ-002 SHALL have parameter NUM_BTN, default 1, fire buttons per port (1..3).
REQ-003 SHALL have parameter DEB_CYCLES, default 16, clocks an input must be stable before it is accepted (1..255).
REQ-004 SHALL have parameter AF_HALF, default 1000, clocks per autofire half-period (2..65535).
REQ-005 SHALL have parameter SETTLE, default 64, idle clocks after a routing change (1..255).
REQ-006 SHALL have port clock, input, 1, system clock; the only clock.
REQ-007 SHALL have port reset_n, input, 1; reset is synchronous and active-low.
REQ-008 SHALL have port joy_in, input, NUM_PORTS*(4+NUM_BTN), active-high per source: bit0 right, bit1 left, bit2 down, bit3 up, bit4+ fire1..fireN; asynchronous to clock.
REQ-009 SHALL have port rotate, input, 2, port rotation: output k takes source (k+rotate) mod NUM_PORTS.
REQ-010 SHALL have port af_en, input, NUM_PORTS, per-output autofire enable.
REQ-011 SHALL have port joy_out, output, NUM_PORTS*8, active-low machine port byte per output.
REQ-012 SHALL have port busy, output, 1, high while in SETTLE.

Function
REQ-013 Each joy_in bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-014 Each synchronised bit SHALL have its own debounce counter; the accepted value updates only after DEB_CYCLES consecutive equal samples that differ from the current accepted value; any mismatch reloads the counter.
REQ-015 Output byte layout (before inversion) SHALL be: bit0 up, bit1 down, bit2 left, bit3 right, bit4 fire2, bit5 fire1, bit6 fire3, bit7 0; missing buttons read 0; joy_out is the bitwise inverse.
REQ-016 When both left and right are accepted as pressed, both SHALL be reported released; the same applies to up and down.
REQ-017 Routing SHALL be a registered mux; latency from accepted value to joy_out SHALL be exactly 1 clock.
REQ-018 FSM states RUN and SETTLE: RUN -> SETTLE when the registered rotate differs from the live rotate; SETTLE -> RUN after SETTLE clocks; in SETTLE every joy_out byte is 8'hFF and busy=1.
REQ-019 A rotate change during SETTLE SHALL restart the SETTLE count and latch the new value.
REQ-020 rotate values >= NUM_PORTS SHALL be reduced modulo NUM_PORTS.
REQ-021 Debouncing SHALL continue during SETTLE, so post-SETTLE outputs reflect current inputs without extra delay.

Reset
REQ-022 While reset_n=0 at a clock edge: synchronisers and accepted values 0, debounce counters cleared, autofire phase 0, FSM RUN, registered rotate 0, joy_out all 8'hFF, busy 0.
REQ-023 On the first edge with reset_n=1, rotate SHALL be compared against 0; a nonzero rotate enters SETTLE.

Configuration
REQ-024 With JOY_ROUTER_AUTOFIRE_EN defined: one shared counter toggles an autofire phase every AF_HALF clocks; for each output with af_en set, fire1 is reported as (fire1 AND phase); the counter free-runs and is not reset by rotate changes.
REQ-025 Without JOY_ROUTER_AUTOFIRE_EN: no autofire counter is synthesised, af_en is ignored, fire1 passes through unchanged.

Structure
REQ-026 Shared package joy_router_pkg SHALL hold the bit-index constants for source and output layouts and the FSM state enum.
REQ-027 Per-bit synchroniser plus debounce SHALL be a sub-module joy_debounce, instantiated NUM_PORTS*(4+NUM_BTN) times.

Verification
REQ-028 Reset, then joy_in port0 up=1 held: joy_out[7:0] becomes 8'hFE exactly 2+DEB_CYCLES+1 clocks after the input change.
REQ-029 Port0 up pulsed for DEB_CYCLES-1 clocks, then released: joy_out[7:0] stays 8'hFF.
REQ-030 Port0 left=1 and right=1 together: joy_out[7:0] = 8'hFF; release right: becomes 8'hFB.
REQ-031 Port1 fire1 held, rotate 0->1: busy=1 and joy_out=all FF for SETTLE clocks, then joy_out[7:0]=8'hDF; second rotate change mid-SETTLE extends busy to a full SETTLE from that change.
REQ-032 AUTOFIRE_EN, AF_HALF=4, af_en[0]=1, port0 fire1 held: joy_out[5] toggles every 4 clocks; with af_en[0]=0 it holds at 0; without the macro it always holds at 0.
REQ-033 NUM_PORTS=3, rotate=3: routing identical to rotate=0.

Source files
------------

// File: rtl/joy_router_pkg.sv
// joy_router_pkg: shared bit layouts and FSM state encoding for joy_router.
// Source bits are indexed as they arrive on joy_in; output bits are indexed
// as they appear in the (pre-inversion) machine port byte.
package joy_router_pkg;

  // Source layout, per joystick port on joy_in
  localparam int SRC_RIGHT = 0;
  localparam int SRC_LEFT  = 1;
  localparam int SRC_DOWN  = 2;
  localparam int SRC_UP    = 3;
  localparam int SRC_FIRE1 = 4;
  localparam int SRC_FIRE2 = 5;
  localparam int SRC_FIRE3 = 6;

  // Number of direction bits that precede the fire buttons in a source group
  localparam int SRC_DIR_W = 4;

  // Output layout, per machine port byte before inversion
  localparam int OUT_UP    = 0;
  localparam int OUT_DOWN  = 1;
  localparam int OUT_LEFT  = 2;
  localparam int OUT_RIGHT = 3;
  localparam int OUT_FIRE2 = 4;
  localparam int OUT_FIRE1 = 5;
  localparam int OUT_FIRE3 = 6;
  localparam int OUT_SPARE = 7;

  // Active-low port byte with nothing pressed
  localparam logic [7:0] OUT_IDLE = 8'hFF;

  // Routing FSM: RUN passes routed data, SETTLE blanks outputs after a
  // rotation change so the machine never sees a half-switched port.
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SETTLE = 1'b1
  } route_state_t;

  // Fold a 2-bit rotate value into 0..num_ports-1. With num_ports in 2..4 and
  // rot in 0..3 a single conditional subtraction is always enough.
  function automatic logic [1:0] reduce_rot(input logic [1:0] rot,
                                            input int num_ports);
    logic [1:0] r;
    r = rot;
    if (int'(rot) >= num_ports) r = rot - 2'(num_ports);
    return r;
  endfunction

endpackage

// File: rtl/joy_debounce.sv
// joy_debounce: one joystick contact. A 2-flop synchroniser brings the
// asynchronous contact into the clock domain, then a per-bit counter only
// accepts a new level after DEB_CYCLES consecutive samples that all differ
// from the currently accepted level. Any sample equal to the accepted level
// reloads the counter, so bounce never leaks through.
module joy_debounce
  import joy_router_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic       sync_a;
  logic       sync_b;
  logic       acc_q;
  logic [7:0] cnt_q;

  // Two-stage synchroniser for the asynchronous contact
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= din;
      sync_b <= sync_a;
    end
  end

  // Stability counter: accept on the DEB_CYCLES-th differing sample in a row
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc_q <= 1'b0;
      cnt_q <= 8'd0;
    end else if (sync_b != acc_q) begin
      if (cnt_q == 8'(DEB_CYCLES - 1)) begin
        acc_q <= sync_b;
        cnt_q <= 8'd0;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end else begin
      cnt_q <= 8'd0;
    end
  end

  assign dout = acc_q;

endmodule

// File: rtl/joy_router.sv
// joy_router: debounces NUM_PORTS joystick sources, maps each to the
// active-low machine port byte layout, rotates sources across outputs and
// registers the result. A rotation change blanks all outputs for SETTLE
// clocks while debouncing keeps running underneath.
// Optional feature: define JOY_ROUTER_AUTOFIRE_EN to add a shared autofire
// phase that gates fire1 on outputs whose af_en bit is set.
module joy_router
  import joy_router_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int NUM_BTN    = 1,
  parameter int DEB_CYCLES = 16,
  parameter int AF_HALF    = 1000,
  parameter int SETTLE     = 64
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [NUM_PORTS*(4+NUM_BTN)-1:0]   joy_in,
  input  logic [1:0]                         rotate,
  input  logic [NUM_PORTS-1:0]               af_en,
  output logic [NUM_PORTS*8-1:0]             joy_out,
  output logic                               busy
);

  localparam int SRC_W    = SRC_DIR_W + NUM_BTN;
  localparam int NUM_BITS = NUM_PORTS * SRC_W;

  // ---------------------------------------------------------------------
  // Per-bit synchroniser + debounce
  // ---------------------------------------------------------------------
  logic [NUM_BITS-1:0] deb_q;

  genvar gi;
  for (gi = 0; gi < NUM_BITS; gi++) begin : g_deb
    joy_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clock  (clock),
      .reset_n(reset_n),
      .din    (joy_in[gi]),
      .dout   (deb_q[gi])
    );
  end

  // ---------------------------------------------------------------------
  // Per-source byte assembly (active-high, before inversion)
  // ---------------------------------------------------------------------
  logic [NUM_PORTS*8-1:0] src_flat;

  genvar gp;
  for (gp = 0; gp < NUM_PORTS; gp++) begin : g_src
    logic [SRC_W-1:0] bits;
    logic             up_c;
    logic             down_c;
    logic             left_c;
    logic             right_c;
    logic             fire1_c;
    logic             fire2_c;
    logic             fire3_c;
    logic [7:0]       byte_c;

    assign bits = deb_q[gp*SRC_W +: SRC_W];

    // Opposing directions pressed together cancel to "released"
    assign up_c    = bits[SRC_UP]    & ~bits[SRC_DOWN];
    assign down_c  = bits[SRC_DOWN]  & ~bits[SRC_UP];
    assign left_c  = bits[SRC_LEFT]  & ~bits[SRC_RIGHT];
    assign right_c = bits[SRC_RIGHT] & ~bits[SRC_LEFT];
    assign fire1_c = bits[SRC_FIRE1];

    if (NUM_BTN >= 2) begin : g_fire2
      assign fire2_c = bits[SRC_FIRE2];
    end else begin : g_no_fire2
      assign fire2_c = 1'b0;
    end

    if (NUM_BTN >= 3) begin : g_fire3
      assign fire3_c = bits[SRC_FIRE3];
    end else begin : g_no_fire3
      assign fire3_c = 1'b0;
    end

    // Place each control at its machine port bit position
    always_comb begin
      byte_c            = 8'h00;
      byte_c[OUT_UP]    = up_c;
      byte_c[OUT_DOWN]  = down_c;
      byte_c[OUT_LEFT]  = left_c;
      byte_c[OUT_RIGHT] = right_c;
      byte_c[OUT_FIRE2] = fire2_c;
      byte_c[OUT_FIRE1] = fire1_c;
      byte_c[OUT_FIRE3] = fire3_c;
      byte_c[OUT_SPARE] = 1'b0;
    end

    assign src_flat[gp*8 +: 8] = byte_c;
  end

  // ---------------------------------------------------------------------
  // Routing FSM
  // ---------------------------------------------------------------------
  route_state_t state_q;
  route_state_t state_d;
  logic [1:0]   rot_live;
  logic [1:0]   rot_q;
  logic [1:0]   rot_d;
  logic [7:0]   settle_cnt_q;
  logic [7:0]   settle_cnt_d;
  logic         rot_change;
  logic         force_idle;

  assign rot_live   = reduce_rot(rotate, NUM_PORTS);
  assign rot_change = (rot_live != rot_q);

  // State register with latched rotation and settle counter
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      rot_q        <= 2'd0;
      settle_cnt_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      rot_q        <= rot_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  // Next state: any rotation change (re)starts a full settle period
  always_comb begin
    state_d      = state_q;
    rot_d        = rot_q;
    settle_cnt_d = settle_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (rot_change) begin
          state_d      = ST_SETTLE;
          rot_d        = rot_live;
          settle_cnt_d = 8'd0;
        end
      end
      ST_SETTLE: begin
        if (rot_change) begin
          rot_d        = rot_live;
          settle_cnt_d = 8'd0;
        end else if (settle_cnt_q == 8'(SETTLE - 1)) begin
          state_d      = ST_RUN;
          settle_cnt_d = 8'd0;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d      = ST_RUN;
        settle_cnt_d = 8'd0;
      end
    endcase
  end

  // FSM outputs: blank the registered bytes on the same edge busy rises
  always_comb begin
    busy       = (state_q == ST_SETTLE);
    force_idle = (state_d == ST_SETTLE);
  end

  // ---------------------------------------------------------------------
  // Autofire gate: bit k is 1 when fire1 on output k may pass
  // ---------------------------------------------------------------------
  logic [NUM_PORTS-1:0] af_mask;

`ifdef JOY_ROUTER_AUTOFIRE_EN
  logic [15:0] af_cnt_q;
  logic        af_phase_q;

  // Free-running half-period counter; rotation changes do not touch it
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      af_cnt_q   <= 16'd0;
      af_phase_q <= 1'b0;
    end else if (af_cnt_q == 16'(AF_HALF - 1)) begin
      af_cnt_q   <= 16'd0;
      af_phase_q <= ~af_phase_q;
    end else begin
      af_cnt_q   <= af_cnt_q + 16'd1;
    end
  end

  assign af_mask = ~af_en | {NUM_PORTS{af_phase_q}};
`else
  logic unused_af_en;
  assign unused_af_en = ^af_en;
  assign af_mask      = '1;
`endif

  // ---------------------------------------------------------------------
  // Routing mux and output register
  // ---------------------------------------------------------------------
  logic [NUM_PORTS*8-1:0] route_d;

  genvar go;
  for (go = 0; go < NUM_PORTS; go++) begin : g_route
    logic [2:0] sum;
    logic [2:0] src_idx;
    logic [7:0] sel_byte;
    logic [7:0] out_byte;

    assign sum = 3'(go) + {1'b0, rot_q};

    // Output go takes source (go + rot_q) mod NUM_PORTS, inverted to active-low
    always_comb begin
      src_idx = (sum >= 3'(NUM_PORTS)) ? (sum - 3'(NUM_PORTS)) : sum;
      sel_byte = src_flat[8*src_idx +: 8];
      out_byte = sel_byte;
      out_byte[OUT_FIRE1] = sel_byte[OUT_FIRE1] & af_mask[go];
      if (force_idle) begin
        out_byte = ~OUT_IDLE;
      end
    end

    assign route_d[go*8 +: 8] = ~out_byte;
  end

  // Registered outputs: exactly one clock from accepted value to joy_out
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      joy_out <= {NUM_PORTS{OUT_IDLE}};
    end else begin
      joy_out <= route_d;
    end
  end

endmodule

// File: tb/tb_joy_router.sv
// tb_joy_router: self-checking bench for joy_router with NUM_PORTS=3,
// NUM_BTN=3, short debounce/settle/autofire periods. Expected port bytes are
// queued when stimulus is applied and popped when the output is due.
`timescale 1ns/1ps
module tb_joy_router;

  localparam int NP  = 3;
  localparam int NB  = 3;
  localparam int DEB = 4;
  localparam int AFH = 4;
  localparam int STL = 8;
  localparam int SW  = 4 + NB;
  // Input change -> joy_out change: 2 sync + DEB debounce + 1 output register
  localparam int LAT = 2 + DEB + 1;

  // Source bit positions within a port group
  localparam int B_RIGHT = 0;
  localparam int B_LEFT  = 1;
  localparam int B_DOWN  = 2;
  localparam int B_UP    = 3;
  localparam int B_F1    = 4;
  localparam int B_F2    = 5;
  localparam int B_F3    = 6;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NP*SW-1:0]  joy_in;
  logic [1:0]        rotate;
  logic [NP-1:0]     af_en;
  logic [NP*8-1:0]   joy_out;
  logic              busy;

  int checks = 0;
  int errors = 0;
  logic [NP*8-1:0] exp_q[$];
  logic            s5[32];

  // Clock
  always #5 clock = ~clock;

  joy_router #(
    .NUM_PORTS (NP),
    .NUM_BTN   (NB),
    .DEB_CYCLES(DEB),
    .AF_HALF   (AFH),
    .SETTLE    (STL)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .joy_in (joy_in),
    .rotate (rotate),
    .af_en  (af_en),
    .joy_out(joy_out),
    .busy   (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n clocks and sample 1ns after the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_src(input int p, input int b, input logic v);
    joy_in[p*SW+b] = v;
  endtask

  task automatic push_exp(input logic [NP*8-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input string tag);
    logic [NP*8-1:0] e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val(tag, 32'(joy_out), 32'(e));
    end
  endtask

  initial begin
    int  first;
    logic found;

    reset_n = 1'b0;
    joy_in  = '0;
    rotate  = 2'd0;
    af_en   = '0;

    // Reset state
    tick(3);
    check_val("rst_out", 32'(joy_out), 32'hFFFFFF);
    check_val("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick(2);
    check_val("idle_busy", 32'(busy), 32'd0);

    // Exact latency of a held press
    set_src(0, B_UP, 1'b1);
    push_exp(24'hFFFFFF);
    push_exp(24'hFFFFFE);
    tick(LAT - 1);
    pop_check("up_before");
    tick(1);
    pop_check("up_after");
    set_src(0, B_UP, 1'b0);
    push_exp(24'hFFFFFF);
    tick(LAT);
    pop_check("up_release");

    // Pulse one clock shorter than the debounce window is rejected
    set_src(0, B_UP, 1'b1);
    tick(DEB - 1);
    set_src(0, B_UP, 1'b0);
    for (int i = 0; i < LAT + 2; i++) begin
      push_exp(24'hFFFFFF);
      tick(1);
      pop_check("short_pulse");
    end

    // Opposing directions cancel
    set_src(0, B_LEFT, 1'b1);
    set_src(0, B_RIGHT, 1'b1);
    push_exp(24'hFFFFFF);
    tick(LAT + 1);
    pop_check("lr_both");
    set_src(0, B_RIGHT, 1'b0);
    push_exp(24'hFFFFFB);
    tick(LAT);
    pop_check("lr_left");
    set_src(0, B_UP, 1'b1);
    set_src(0, B_DOWN, 1'b1);
    push_exp(24'hFFFFFB);
    tick(LAT + 1);
    pop_check("ud_both");
    set_src(0, B_DOWN, 1'b0);
    push_exp(24'hFFFFFA);
    tick(LAT);
    pop_check("up_left");
    joy_in = '0;
    push_exp(24'hFFFFFF);
    tick(LAT);
    pop_check("clear_a");

    // Fire2/fire3 positions on port2, up on port1
    set_src(2, B_F2, 1'b1);
    set_src(2, B_F3, 1'b1);
    set_src(1, B_UP, 1'b1);
    push_exp(24'hAFFEFF);
    tick(LAT);
    pop_check("fire23_up");
    joy_in = '0;
    push_exp(24'hFFFFFF);
    tick(LAT);
    pop_check("clear_b");

    // Rotation with port1 fire1 held
    set_src(1, B_F1, 1'b1);
    push_exp(24'hFFDFFF);
    tick(LAT);
    pop_check("f1_rot0");
    rotate = 2'd1;
    check_val("busy_pre", 32'(busy), 32'd0);
    for (int k = 1; k <= STL; k++) begin
      tick(1);
      check_val("settle_busy", 32'(busy), 32'd1);
      push_exp(24'hFFFFFF);
      pop_check("settle_out");
    end
    tick(1);
    check_val("settle_done", 32'(busy), 32'd0);
    push_exp(24'hFFFFDF);
    pop_check("rot1");

    // Second change mid-settle restarts the full period
    rotate = 2'd2;
    tick(3);
    check_val("mid_busy", 32'(busy), 32'd1);
    rotate = 2'd0;
    for (int k = 1; k <= STL; k++) begin
      tick(1);
      check_val("ext_busy", 32'(busy), 32'd1);
    end
    tick(1);
    check_val("ext_done", 32'(busy), 32'd0);
    push_exp(24'hFFDFFF);
    pop_check("rot0");

    rotate = 2'd2;
    tick(STL + 1);
    check_val("rot2_busy", 32'(busy), 32'd0);
    push_exp(24'hDFFFFF);
    pop_check("rot2");

    // rotate=3 folds to 0; a press made during settle is visible right after
    rotate = 2'd3;
    set_src(0, B_RIGHT, 1'b1);
    tick(STL + 1);
    check_val("rot3_busy", 32'(busy), 32'd0);
    push_exp(24'hFFDFF7);
    pop_check("rot3");
    rotate = 2'd0;
    tick(1);
    check_val("rot3_to_0_busy", 32'(busy), 32'd0);
    push_exp(24'hFFDFF7);
    pop_check("rot3_to_0");

    // Autofire on output0
    joy_in = '0;
    set_src(0, B_F1, 1'b1);
    tick(LAT + 1);
    for (int i = 0; i < 8; i++) begin
      check_val("af_off", 32'(joy_out[5]), 32'd0);
      tick(1);
    end
    af_en[0] = 1'b1;
    for (int j = 0; j < 32; j++) begin
      tick(1);
      s5[j] = joy_out[5];
    end
`ifdef JOY_ROUTER_AUTOFIRE_EN
    found = 1'b0;
    first = 0;
    for (int j = 1; j < 32; j++) begin
      if (!found && (s5[j] != s5[j-1])) begin
        found = 1'b1;
        first = j;
      end
    end
    check_val("af_edge", 32'(found), 32'd1);
    if (found) begin
      for (int j = first + 1; j < 32; j++) begin
        check_val("af_toggle", 32'(s5[j]),
                  32'(s5[first] ^ 1'(((j - first) / AFH) % 2)));
      end
    end
`else
    found = 1'b0;
    first = 0;
    for (int j = 0; j < 32; j++) begin
      check_val("af_nomacro", 32'(s5[j]), 32'd0);
    end
`endif
    af_en[0] = 1'b0;
    tick(2);
    for (int i = 0; i < 6; i++) begin
      check_val("af_disabled", 32'(joy_out[5]), 32'd0);
      tick(1);
    end

    // Reset with nonzero rotate enters settle on the first released edge
    rotate  = 2'd2;
    reset_n = 1'b0;
    tick(2);
    check_val("rst2_out", 32'(joy_out), 32'hFFFFFF);
    check_val("rst2_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick(1);
    check_val("rst_exit_busy", 32'(busy), 32'd1);
    check_val("rst_exit_out", 32'(joy_out), 32'hFFFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
